// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register addresses, exception type codes, field positions
// and the exception decode helpers used by cp0_reg.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam int STATUS_EXL_BIT  = 1;
  localparam int CAUSE_EXC_LSB   = 2;
  localparam int CAUSE_EXC_MSB   = 6;
  localparam int CAUSE_IP_SW_LSB = 8;
  localparam int CAUSE_IP_SW_MSB = 9;
  localparam int CAUSE_IP_HW_LSB = 10;
  localparam int CAUSE_IP_HW_MSB = 15;
  localparam int CAUSE_WP_BIT    = 22;
  localparam int CAUSE_IV_BIT    = 23;
  localparam int CAUSE_BD_BIT    = 31;

  typedef enum logic [1:0] {
    EXC_ACT_NONE,
    EXC_ACT_TAKE,
    EXC_ACT_RETURN
  } exc_action_e;

  function automatic exc_action_e exc_action(input logic [31:0] exc_type);
    case (exc_type)
      EXC_INT, EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP: exc_action = EXC_ACT_TAKE;
      EXC_ERET:                                       exc_action = EXC_ACT_RETURN;
      default:                                        exc_action = EXC_ACT_NONE;
    endcase
  endfunction

  // Interrupts map to ExcCode 0; the other taken exceptions reuse their type code.
  function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
    if (exc_type == EXC_INT) exc_code = 5'd0;
    else                     exc_code = exc_type[4:0];
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair and the sticky timer interrupt.
// Timer interrupt generation only exists when CP0_TIMER_INT_EN is defined.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      compare <= '0;
    end else begin
      count <= count_we ? data : count + 32'd1;
      if (compare_we) compare <= data;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic timer_q;

  // Compare==0 means the timer is disarmed; a Compare write acknowledges the interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= 1'b0;
    end else if (compare_we) begin
      timer_q <= 1'b0;
    end else if (compare != '0 && count == compare) begin
      timer_q <= 1'b1;
    end
  end

  assign timer_int = timer_q;
`else
  assign timer_int = 1'b0;
`endif

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file with precise exception capture and mfc0 read port.
// Defining CP0_TIMER_INT_EN enables the timer interrupt and its Cause.IP[7] override.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
  parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic        count_we;
  logic        compare_we;

  assign count_we   = we_i && (waddr_i == CP0_REG_COUNT);
  assign compare_we = we_i && (waddr_i == CP0_REG_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .data       (data_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );

  // Exception updates follow the software write so they take priority on overlapping bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      cause_q[CAUSE_IP_HW_MSB:CAUSE_IP_HW_LSB] <= int_i;
      if (we_i) begin
        case (waddr_i)
          CP0_REG_STATUS: status_q <= data_i;
          CP0_REG_EPC:    epc_q    <= data_i;
          CP0_REG_CAUSE: begin
            cause_q[CAUSE_IP_SW_MSB:CAUSE_IP_SW_LSB] <= data_i[CAUSE_IP_SW_MSB:CAUSE_IP_SW_LSB];
            cause_q[CAUSE_WP_BIT] <= data_i[CAUSE_WP_BIT];
            cause_q[CAUSE_IV_BIT] <= data_i[CAUSE_IV_BIT];
          end
          default: ;
        endcase
      end
      case (exc_action(excepttype_i))
        EXC_ACT_TAKE: begin
          if (!status_q[STATUS_EXL_BIT]) begin
            epc_q <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
            cause_q[CAUSE_BD_BIT] <= is_in_delayslot_i;
          end
          status_q[STATUS_EXL_BIT] <= 1'b1;
          cause_q[CAUSE_EXC_MSB:CAUSE_EXC_LSB] <= exc_code(excepttype_i);
        end
        EXC_ACT_RETURN: status_q[STATUS_EXL_BIT] <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic unused_ip7;
  assign unused_ip7 = cause_q[CAUSE_IP_HW_MSB];
  assign cause_o    = {cause_q[31:CAUSE_IP_HW_MSB+1], timer_int_o, cause_q[CAUSE_IP_HW_MSB-1:0]};
`else
  assign cause_o    = cause_q;
`endif

  assign status_o = status_q;
  assign epc_o    = epc_q;
  assign config_o = CONFIG_VALUE;
  assign prid_o   = PRID_VALUE;

  always_comb begin
    data_o = '0;
    case (raddr_i)
      CP0_REG_COUNT:   data_o = count_o;
      CP0_REG_COMPARE: data_o = compare_o;
      CP0_REG_STATUS:  data_o = status_o;
      CP0_REG_CAUSE:   data_o = cause_o;
      CP0_REG_EPC:     data_o = epc_o;
      CP0_REG_PRID:    data_o = PRID_VALUE;
      CP0_REG_CONFIG:  data_o = CONFIG_VALUE;
      default:         data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg; expectations follow the CP0_TIMER_INT_EN setting of the build.
module tb_cp0_reg;

`ifdef CP0_TIMER_INT_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .data_i              (data_i),
    .raddr_i             (raddr_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    we_i = 1'b0; waddr_i = '0; data_i = '0; raddr_i = '0; int_i = '0;
    excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic raise(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    step();
    excepttype_i = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (count_o !== 32'd0) begin n_fail++; $display("FAIL reset_count got %h want %h", count_o, 32'd0); end
    repeat (5) step();
    n_checks++;
    if (count_o !== 32'd5) begin n_fail++; $display("FAIL idle_count got %h want %h", count_o, 32'd5); end
    n_checks++;
    if (status_o !== 32'h1000_0000) begin n_fail++; $display("FAIL reset_status got %h want %h", status_o, 32'h1000_0000); end
    n_checks++;
    if (cause_o !== 32'd0) begin n_fail++; $display("FAIL reset_cause got %h want %h", cause_o, 32'd0); end
    n_checks++;
    if (epc_o !== 32'd0 || timer_int_o !== 1'b0) begin n_fail++; $display("FAIL reset_epc_timer got %h/%b want 0/0", epc_o, timer_int_o); end
    raddr_i = 5'd15; #1;
    n_checks++;
    if (data_o !== 32'h004c_0102) begin n_fail++; $display("FAIL read_prid got %h want %h", data_o, 32'h004c_0102); end
    raddr_i = 5'd16; #1;
    n_checks++;
    if (data_o !== 32'h0000_8000) begin n_fail++; $display("FAIL read_config got %h want %h", data_o, 32'h0000_8000); end
    raddr_i = 5'd9; #1;
    n_checks++;
    if (data_o !== 32'd5) begin n_fail++; $display("FAIL read_count got %h want %h", data_o, 32'd5); end
  endtask

  task automatic test_timer();
    do_reset();
    write_reg(5'd11, 32'd10);
    write_reg(5'd9, 32'd0);
    n_checks++;
    if (count_o !== 32'd0 || compare_o !== 32'd10) begin n_fail++; $display("FAIL count_compare_load got %h/%h want 0/a", count_o, compare_o); end
    for (int i = 0; i < 30 && count_o !== 32'd10; i++) step();
    n_checks++;
    if (count_o !== 32'd10 || timer_int_o !== 1'b0) begin n_fail++; $display("FAIL pre_match got %h/%b want a/0", count_o, timer_int_o); end
    step();
    n_checks++;
    if (timer_int_o !== TIMER_EN) begin n_fail++; $display("FAIL timer_fire got %b want %b", timer_int_o, TIMER_EN); end
    n_checks++;
    if (cause_o[15] !== TIMER_EN) begin n_fail++; $display("FAIL cause_ip7 got %b want %b", cause_o[15], TIMER_EN); end
    repeat (3) step();
    n_checks++;
    if (timer_int_o !== TIMER_EN) begin n_fail++; $display("FAIL timer_sticky got %b want %b", timer_int_o, TIMER_EN); end
    write_reg(5'd11, 32'd50);
    n_checks++;
    if (timer_int_o !== 1'b0 || compare_o !== 32'd50) begin n_fail++; $display("FAIL timer_clear got %b/%h want 0/32", timer_int_o, compare_o); end
  endtask

  task automatic test_exception();
    do_reset();
    raise(32'h8, 32'hBFC0_0100, 1'b0);
    n_checks++;
    if (epc_o !== 32'hBFC0_0100) begin n_fail++; $display("FAIL syscall_epc got %h want %h", epc_o, 32'hBFC0_0100); end
    n_checks++;
    if (status_o !== 32'h1000_0002) begin n_fail++; $display("FAIL syscall_status got %h want %h", status_o, 32'h1000_0002); end
    n_checks++;
    if (cause_o[6:2] !== 5'd8 || cause_o[31] !== 1'b0) begin n_fail++; $display("FAIL syscall_cause got %h want code 8 bd 0", cause_o); end
    raddr_i = 5'd14; #1;
    n_checks++;
    if (data_o !== 32'hBFC0_0100) begin n_fail++; $display("FAIL read_epc got %h want %h", data_o, 32'hBFC0_0100); end
  endtask

  task automatic test_delayslot_nested();
    do_reset();
    raise(32'hc, 32'h200, 1'b1);
    n_checks++;
    if (epc_o !== 32'h1FC || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd12) begin
      n_fail++; $display("FAIL ov_delayslot got epc %h cause %h want epc 1fc bd 1 code 12", epc_o, cause_o);
    end
    raise(32'ha, 32'h300, 1'b0);
    n_checks++;
    if (epc_o !== 32'h1FC) begin n_fail++; $display("FAIL nested_epc got %h want %h", epc_o, 32'h1FC); end
    n_checks++;
    if (cause_o[6:2] !== 5'd10 || cause_o[31] !== 1'b1) begin n_fail++; $display("FAIL nested_cause got %h want code 10 bd 1", cause_o); end
    raise(32'h7, 32'h400, 1'b0);
    n_checks++;
    if (epc_o !== 32'h1FC || cause_o[6:2] !== 5'd10 || status_o !== 32'h1000_0002) begin
      n_fail++; $display("FAIL unknown_code got epc %h cause %h status %h want no change", epc_o, cause_o, status_o);
    end
  endtask

  task automatic test_cause_eret();
    do_reset();
    int_i = 6'b101010;
    write_reg(5'd13, 32'hFFFF_FFFF);
    n_checks++;
    if (cause_o !== (TIMER_EN ? 32'h00C0_2B00 : 32'h00C0_AB00)) begin
      n_fail++; $display("FAIL cause_write got %h want %h", cause_o, (TIMER_EN ? 32'h00C0_2B00 : 32'h00C0_AB00));
    end
    write_reg(5'd12, 32'h1000_0003);
    n_checks++;
    if (status_o !== 32'h1000_0003) begin n_fail++; $display("FAIL status_write got %h want %h", status_o, 32'h1000_0003); end
    raise(32'he, 32'h0, 1'b0);
    n_checks++;
    if (status_o !== 32'h1000_0001) begin n_fail++; $display("FAIL eret got %h want %h", status_o, 32'h1000_0001); end
    write_reg(5'd5, 32'hDEAD_BEEF);
    raddr_i = 5'd5; #1;
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL unmapped_read got %h want %h", data_o, 32'd0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_reg(5'd11, 32'd5);
    write_reg(5'd14, 32'h1234);
    write_reg(5'd9, 32'd0);
    for (int i = 0; i < 200 && count_o !== 32'd123; i++) step();
    n_checks++;
    if (count_o !== 32'd123 || timer_int_o !== TIMER_EN) begin n_fail++; $display("FAIL pre_reset got %h/%b want 7b/%b", count_o, timer_int_o, TIMER_EN); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (count_o !== 32'd0 || compare_o !== 32'd0 || epc_o !== 32'd0 || timer_int_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got count %h cmp %h epc %h tmr %b want all 0", count_o, compare_o, epc_o, timer_int_o);
    end
    n_checks++;
    if (status_o !== 32'h1000_0000 || cause_o !== 32'd0) begin n_fail++; $display("FAIL async_reset_sc got %h/%h want 10000000/0", status_o, cause_o); end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (count_o !== 32'd1) begin n_fail++; $display("FAIL resume_count got %h want %h", count_o, 32'd1); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_exception();
    test_delayslot_nested();
    test_cause_eret();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
